// File: rtl/projectile_pkg.sv
// Shared types and default tuning for the player projectile pool.
// Used by projectile_slot and projectile_pool (see PROJECTILE_AUTOFIRE_EN in the top).
package projectile_pkg;

  localparam int XW = 10;
  localparam int PW = XW + 2;

  localparam int SPEED_DEF    = 10;
  localparam int COOLDOWN_DEF = 8;
  localparam int X_MIN_DEF    = 1;
  localparam int X_MAX_DEF    = 639;
  localparam int Y_OFFSET_DEF = 17;
  localparam logic [7:0] FIRE_KEY_DEF = 8'h2C;

  // Two guard bits so x +/- SPEED never wraps before the wall compare.
  typedef logic signed [PW-1:0] pos_t;

  typedef struct packed {
    logic          active;
    logic [XW-1:0] x;
    logic [XW-1:0] y;
    logic          dir;
  } slot_t;

  function automatic pos_t to_pos(input logic [XW-1:0] v);
    return pos_t'({2'b00, v});
  endfunction

  function automatic pos_t abs_pos(input pos_t v);
    return (v < 0) ? -v : v;
  endfunction

endpackage

// File: rtl/projectile_slot.sv
// One bullet slot: holds position/direction, advances once per frame and
// retires on a boss hit (checked first) or on reaching either wall.
module projectile_slot
  import projectile_pkg::*;
#(
  parameter int SPEED = SPEED_DEF,
  parameter int X_MIN = X_MIN_DEF,
  parameter int X_MAX = X_MAX_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable_i,
  input  logic          spawn_i,
  input  logic [XW-1:0] spawn_x_i,
  input  logic [XW-1:0] spawn_y_i,
  input  logic          spawn_dir_i,
  input  logic [XW-1:0] boss_x_i,
  input  logic [XW-1:0] boss_y_i,
  input  logic [XW-1:0] boss_s_i,
  output logic          active_o,
  output logic          active_d_o,
  output logic [XW-1:0] x_o,
  output logic [XW-1:0] y_o,
  output logic          hit_o
);

  slot_t slot_q, slot_d;
  pos_t  nx;
  logic  hit, wall;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    slot_d = slot_q;
    hit    = 1'b0;
    wall   = 1'b0;
    nx     = slot_q.dir ? to_pos(slot_q.x) + pos_t'(SPEED)
                        : to_pos(slot_q.x) - pos_t'(SPEED);
    if (!enable_i) begin
      slot_d.active = 1'b0;
    end else if (spawn_i) begin
      slot_d = '{active: 1'b1, x: spawn_x_i, y: spawn_y_i, dir: spawn_dir_i};
    end else if (slot_q.active) begin
      hit  = (abs_pos(nx - to_pos(boss_x_i)) <= to_pos(boss_s_i)) &&
             (abs_pos(to_pos(slot_q.y) - to_pos(boss_y_i)) <= to_pos(boss_s_i));
      wall = (nx >= pos_t'(X_MAX)) || (nx <= pos_t'(X_MIN));
      if (hit || wall) slot_d.active = 1'b0;
      else             slot_d.x      = nx[XW-1:0];
    end
  end

  // NOTE: state registers use non-blocking assignments so all slots update from the same old values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) slot_q <= '0;
    else        slot_q <= slot_d;
  end

  assign active_o   = slot_q.active;
  assign active_d_o = slot_d.active;
  assign x_o        = slot_q.x;
  assign y_o        = slot_q.y;
  assign hit_o      = hit;

endmodule

// File: rtl/projectile_pool.sv
// Multi-shot projectile engine: fire detection, lowest-free-slot allocation,
// cooldown and saturating hit counting. Define PROJECTILE_AUTOFIRE_EN for held-key autofire.
module projectile_pool
  import projectile_pkg::*;
#(
  parameter int         NUM_SLOTS = 4,
  parameter int         SPEED     = SPEED_DEF,
  parameter int         COOLDOWN  = COOLDOWN_DEF,
  parameter int         X_MIN     = X_MIN_DEF,
  parameter int         X_MAX     = X_MAX_DEF,
  parameter int         Y_OFFSET  = Y_OFFSET_DEF,
  parameter logic [7:0] FIRE_KEY  = FIRE_KEY_DEF
) (
  input  logic                    frame_clk,
  input  logic                    Reset_n,
  input  logic                    enable,
  input  logic [7:0]              keycode,
  input  logic [XW-1:0]           shooterX,
  input  logic [XW-1:0]           shooterY,
  input  logic                    direction,
  input  logic [XW-1:0]           BossX,
  input  logic [XW-1:0]           BossY,
  input  logic [XW-1:0]           BossS,
  output logic [XW*NUM_SLOTS-1:0] bulletX,
  output logic [XW*NUM_SLOTS-1:0] bulletY,
  output logic [NUM_SLOTS-1:0]    bullet_active,
  output logic                    hit_pulse,
  output logic [7:0]              hit_count,
  output logic                    pool_full
);

  logic                 key_now, fire_req, accept, found;
  logic                 prev_q, hit_pulse_q, pool_full_q;
  logic [7:0]           cd_q, cd_d, hit_count_q, hit_count_d;
  logic [NUM_SLOTS-1:0] active_nxt, hit, spawn;
  logic [3:0]           hit_sum;
  logic [8:0]           count_sum;
  logic [XW-1:0]        spawn_y;

  assign key_now = (keycode == FIRE_KEY);
  assign spawn_y = shooterY + XW'(Y_OFFSET);

`ifdef PROJECTILE_AUTOFIRE_EN
  assign fire_req = key_now;
`else
  assign fire_req = key_now & ~prev_q;
`endif

  // A request that cannot be served now is dropped, never queued.
  assign accept = enable && fire_req && (cd_q == 8'd0) && !(&bullet_active);

  always_comb begin
    spawn = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (accept && !bullet_active[i] && !found) begin
        spawn[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    if (!enable)          cd_d = 8'd0;
    else if (accept)      cd_d = 8'(COOLDOWN);
    else if (cd_q != 8'd0) cd_d = cd_q - 8'd1;
    else                  cd_d = cd_q;
  end

  always_comb begin
    hit_sum = '0;
    for (int i = 0; i < NUM_SLOTS; i++) hit_sum = hit_sum + 4'(hit[i]);
    count_sum   = {1'b0, hit_count_q} + 9'(hit_sum);
    hit_count_d = count_sum[8] ? 8'hFF : count_sum[7:0];
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    projectile_slot #(
      .SPEED (SPEED),
      .X_MIN (X_MIN),
      .X_MAX (X_MAX)
    ) u_slot (
      .clk         (frame_clk),
      .rst_n       (Reset_n),
      .enable_i    (enable),
      .spawn_i     (spawn[g]),
      .spawn_x_i   (shooterX),
      .spawn_y_i   (spawn_y),
      .spawn_dir_i (direction),
      .boss_x_i    (BossX),
      .boss_y_i    (BossY),
      .boss_s_i    (BossS),
      .active_o    (bullet_active[g]),
      .active_d_o  (active_nxt[g]),
      .x_o         (bulletX[g*XW +: XW]),
      .y_o         (bulletY[g*XW +: XW]),
      .hit_o       (hit[g])
    );
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      prev_q      <= 1'b0;
      cd_q        <= 8'd0;
      hit_pulse_q <= 1'b0;
      hit_count_q <= 8'd0;
      pool_full_q <= 1'b0;
    end else begin
      prev_q      <= key_now;
      cd_q        <= cd_d;
      hit_pulse_q <= |hit;
      hit_count_q <= hit_count_d;
      pool_full_q <= &active_nxt;
    end
  end

  assign hit_pulse = hit_pulse_q;
  assign hit_count = hit_count_q;
  assign pool_full = pool_full_q;

endmodule

// File: tb/tb_projectile_pool.sv
// Directed bench for projectile_pool: spawn/motion, cooldown, pool full,
// slot reuse, held key, boss hit, left wall, enable low and async reset.
module tb_projectile_pool;

  localparam int NS = 4;

  logic           frame_clk = 1'b0;
  logic           Reset_n;
  logic           enable;
  logic [7:0]     keycode;
  logic [9:0]     shooterX, shooterY;
  logic           direction;
  logic [9:0]     BossX, BossY, BossS;
  logic [10*NS-1:0] bulletX, bulletY;
  logic [NS-1:0]  bullet_active;
  logic           hit_pulse;
  logic [7:0]     hit_count;
  logic           pool_full;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  projectile_pool #(.NUM_SLOTS(NS)) dut (
    .frame_clk     (frame_clk),
    .Reset_n       (Reset_n),
    .enable        (enable),
    .keycode       (keycode),
    .shooterX      (shooterX),
    .shooterY      (shooterY),
    .direction     (direction),
    .BossX         (BossX),
    .BossY         (BossY),
    .BossS         (BossS),
    .bulletX       (bulletX),
    .bulletY       (bulletY),
    .bullet_active (bullet_active),
    .hit_pulse     (hit_pulse),
    .hit_count     (hit_count),
    .pool_full     (pool_full)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge frame_clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  // Fire key high for exactly the next edge.
  task automatic press();
    keycode = 8'h2C;
    step();
    keycode = 8'h00;
  endtask

  task automatic do_reset();
    @(negedge frame_clk);
    Reset_n   = 1'b0;
    enable    = 1'b1;
    keycode   = 8'h00;
    shooterX  = 10'd200;
    shooterY  = 10'd384;
    direction = 1'b1;
    BossX     = 10'd1000;
    BossY     = 10'd1000;
    BossS     = 10'd0;
    @(negedge frame_clk);
    Reset_n = 1'b1;
    cyc     = 0;
  endtask

  initial begin
    Reset_n = 1'b0;
    enable = 1'b1; keycode = 8'h00; direction = 1'b1;
    shooterX = 10'd200; shooterY = 10'd384;
    BossX = 10'd1000; BossY = 10'd1000; BossS = 10'd0;
    #2;
    check("rst_active", bullet_active, 0);
    check("rst_x",      bulletX, 0);
    check("rst_y",      bulletY, 0);
    check("rst_pulse",  hit_pulse, 0);
    check("rst_count",  hit_count, 0);
    check("rst_full",   pool_full, 0);

    // Spawn and motion, then cooldown / pool full / reuse.
    do_reset();
    press();                                    // E1
    check("spawn_active", bullet_active, 4'b0001);
    check("spawn_x",      bulletX[9:0], 200);
    check("spawn_y",      bulletY[9:0], 401);
    step();
    check("move1_x", bulletX[9:0], 210);
    step();
    check("move2_x", bulletX[9:0], 220);
    press();                                    // E4, cooldown still running
    check("cooldown_drop", bullet_active, 4'b0001);
    run_to(9);
    press();                                    // E10
    check("second_shot", bullet_active, 4'b0011);
    check("slot1_x",     bulletX[19:10], 200);
    check("slot0_x_e10", bulletX[9:0], 290);
    run_to(18);
    press();                                    // E19
    run_to(27);
    press();                                    // E28
    check("four_active", bullet_active, 4'b1111);
    check("pool_full",   pool_full, 1);
    run_to(36);
    press();                                    // E37, no free slot
    check("fifth_drop", bullet_active, 4'b1111);
    run_to(44);
    check("pre_wall_x", bulletX[9:0], 630);
    step();                                     // E45: nx = 640 >= X_MAX
    check("wall_retire", bullet_active, 4'b1110);
    check("wall_keep_x", bulletX[9:0], 630);
    check("full_clear",  pool_full, 0);
    press();                                    // E46
    check("reuse_slot0", bullet_active, 4'b1111);
    check("reuse_x",     bulletX[9:0], 200);

    // Held key for 40 frames.
    do_reset();
    keycode = 8'h2C;
    run_to(40);
    keycode = 8'h00;
`ifdef PROJECTILE_AUTOFIRE_EN
    check("hold_active", bullet_active, 4'b1111);
    check("hold_x3",     bulletX[39:30], 320);
`else
    check("hold_active", bullet_active, 4'b0001);
`endif
    check("hold_x0", bulletX[9:0], 590);

    // Boss hit at nx = 370.
    do_reset();
    BossX = 10'd400; BossY = 10'd401; BossS = 10'd30;
    press();                                    // E1
    run_to(17);
    check("prehit_x",     bulletX[9:0], 360);
    check("prehit_pulse", hit_pulse, 0);
    step();                                     // E18
    check("hit_active", bullet_active, 4'b0000);
    check("hit_pulse",  hit_pulse, 1);
    check("hit_count",  hit_count, 1);
    check("hit_keep_x", bulletX[9:0], 360);
    step();
    check("pulse_one_cycle", hit_pulse, 0);
    check("count_hold",      hit_count, 1);

    // enable low: slots clear, hit_count held.
    BossX = 10'd1000; BossY = 10'd1000; BossS = 10'd0;
    press();
    check("en_spawn", bullet_active, 4'b0001);
    enable = 1'b0;
    step();
    check("en_clear",  bullet_active, 4'b0000);
    check("en_count",  hit_count, 1);
    enable = 1'b1;

    // Leftward from x = 15: 5, then -5 retires with no wrap.
    do_reset();
    shooterX  = 10'd15;
    direction = 1'b0;
    press();
    check("left_spawn_x", bulletX[9:0], 15);
    step();
    check("left_x5",      bulletX[9:0], 5);
    check("left_active",  bullet_active, 4'b0001);
    step();
    check("left_retire",  bullet_active, 4'b0000);
    check("left_no_wrap", bulletX[9:0], 5);

    // Asynchronous reset mid-flight, then fire on the first edge after release.
    do_reset();
    press();
    step();
    step();
    #2;
    Reset_n = 1'b0;
    #1;
    check("async_active", bullet_active, 0);
    check("async_x",      bulletX, 0);
    check("async_y",      bulletY, 0);
    keycode = 8'h2C;
    @(negedge frame_clk);
    Reset_n = 1'b1;
    step();
    keycode = 8'h00;
    check("post_rst_fire", bullet_active, 4'b0001);
    check("post_rst_y",    bulletY[9:0], 401);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/projectile_pool.md
# projectile_pool

Parametrised multi-shot projectile engine for the player, replacing the single hard-wired bullet in the player controller. It holds NUM_SLOTS independent bullets, spawns them from the shooter position on a fire key, moves them once per frame, and retires them at the level walls or on a boss hit. Hits are reported to the boss-health logic. Sits between the keycode decoder and the sprite/boss blocks, clocked by frame_clk.

## Interface
- NUM_SLOTS, 4: concurrent bullets (1..8)
- SPEED, 10: pixels per frame
- COOLDOWN, 8: frames between shots
- X_MIN, 1 / X_MAX, 639: horizontal wall limits
- Y_OFFSET, 17: spawn Y offset below shooterY
- FIRE_KEY, 8'h2C: keycode that fires
- frame_clk  in  1  frame clock, all state on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- enable  in  1  game running (low in menu/game over)
- keycode  in  8  current keycode
- shooterX, shooterY  in  10  player centre
- direction  in  1  1 = right, 0 = left
- BossX, BossY, BossS  in  10  boss centre and half-size
- bulletX, bulletY  out  10*NUM_SLOTS  packed slot positions, slot 0 in LSBs
- bullet_active  out  NUM_SLOTS  slot flying
- hit_pulse  out  1  one-cycle pulse, one or more hits this frame
- hit_count  out  8  saturating total hits
- pool_full  out  1  all slots active

## Operation
- Slot states: IDLE, FLYING. Each slot stores x, y, and a direction bit.
- Fire request:
  - Default: rising edge of (keycode == FIRE_KEY), using a registered previous-key flag.
  - Accepted only when enable = 1, cooldown = 0, and at least one slot is IDLE.
- Allocation: the lowest-index IDLE slot is loaded with x = shooterX, y = shooterY + Y_OFFSET, dir = direction, and goes to FLYING. Cooldown is loaded with COOLDOWN.
- A request that finds no free slot or nonzero cooldown is dropped, not queued.
- Each cycle, every FLYING slot (except one spawned this cycle) computes nx = x ± SPEED, in signed XW+2 arithmetic (no wrap-around).
- A slot retires to IDLE when any of these holds:
  - hit: |nx − BossX| ≤ BossS and |y − BossY| ≤ BossS
  - wall: nx ≥ X_MAX or nx ≤ X_MIN
- Otherwise x ← nx. Hit has priority over wall; a retired slot keeps its last x.
- A slot retired in cycle n is not allocatable until cycle n+1.
- Per cycle, hit_count increases by the number of slots hit that cycle, saturating at 255. hit_pulse = 1 if that number is nonzero.
- Cooldown decrements by 1 per cycle while nonzero.
- enable = 0: all slots go IDLE, cooldown is cleared, the previous-key flag is updated, and hit_count is held.

## Timing
- Reset values: bullet_active 0, bulletX/bulletY 0, hit_pulse 0, hit_count 0, pool_full 0, cooldown 0, previous-key flag 0.
- Fire seen at cycle n: the slot is active with its spawn position at cycle n+1, and first moves at n+2.
- Hit detected at cycle n: hit_pulse, hit_count, and the bullet_active clear all appear at n+1.
- Minimum shot spacing is COOLDOWN+1 cycles.
- pool_full is registered and reflects slot state after the current update.
- Reset_n asserted mid-flight clears everything asynchronously. The first fire is possible on the first clock edge after deassertion, given a key rising edge.

## Configuration
- PROJECTILE_AUTOFIRE_EN defined: fire request is level-sensitive (keycode == FIRE_KEY); holding the key fires every COOLDOWN+1 frames while a slot is free.
- Undefined: edge-triggered only; holding the key yields exactly one shot.

## Structure
- Package projectile_pkg holds:
  - typedef slot_t {active, x[9:0], y[9:0], dir}
  - typedef pos_t (signed 12-bit)
  - defaults for SPEED, COOLDOWN, X_MIN, X_MAX, FIRE_KEY
- Sub-module projectile_slot: one slot's state, motion, wall and hit check. Instantiated NUM_SLOTS times by generate.
- Top level handles allocation priority, cooldown, edge detection, hit summation, and saturation.

## Test plan
- Reset, then keycode 2C for one frame with shooter (200, 384), dir 1: slot 0 at (200, 401) next cycle, then (210, 401), (220, 401).
- Four presses spaced 9 frames apart with NUM_SLOTS=4: slots 0..3 active, pool_full=1. A fifth press is dropped. After slot 0 hits the wall, the next press reuses slot 0.
- Two presses 3 frames apart: second is ignored (cooldown). Without the macro, holding 2C for 40 frames produces one bullet; with PROJECTILE_AUTOFIRE_EN it produces 4 shots (frames 0, 9, 18, 27).
- Boss at (400, 401), BossS 30, bullet moving right from 200: hit when nx = 370; hit_pulse for one cycle, hit_count 0→1, slot IDLE.
- Dir 0 from x = 15: nx = 5 retires the slot cleanly, with no wrap to a large value. Reset_n low mid-flight clears all outputs immediately.
